// File: rtl/sample_capture_scheduler.sv
// sample_capture_scheduler
// Drives capture into a NUM_CHANNELS x SAMPLES_DEPTH x 8-bit shift-buffer bank.
// A programmable divider produces a sample tick. Each tick starts a fixed-length
// scan that visits every channel once and strobes a write for enabled channels.
// The bank has one access port. Capture writes always own it and host reads get
// the idle cycles. The block also tracks completed frames (fill) and dropped ticks
// (overrun).
// Optional build macro: SCHED_OVERRUN_CNT_EN adds an 8-bit saturating count of
// dropped ticks (overrun_cnt).
//
// Read handshake: the host raises rd_req with rd_ch and holds both until it sees
// rd_gnt. rd_gnt is a single-cycle pulse. In that cycle the bank port belongs to
// the reader, and rd_gnt_ch holds the channel that was captured. A cycle is granted
// only when no capture write is scheduled in it. While rd_req stays high, one idle
// cycle always separates consecutive grants.
module sample_capture_scheduler #(
  parameter int NUM_CHANNELS   = 14,
  parameter int SAMPLES_DEPTH  = 10,
  parameter int DIV_WIDTH      = 16,
  localparam int CH_W          = $clog2(NUM_CHANNELS),
  localparam int FILL_W        = $clog2(SAMPLES_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [DIV_WIDTH-1:0]    period,
  input  logic [NUM_CHANNELS-1:0] ch_mask,
  input  logic                    clr,
  output logic                    wr_en,
  output logic [CH_W-1:0]         wr_ch,
  output logic                    frame_done,
  output logic [FILL_W-1:0]       fill,
  output logic                    buf_full,
  output logic                    overrun,
`ifdef SCHED_OVERRUN_CNT_EN
  output logic [7:0]              overrun_cnt,
`endif
  input  logic                    rd_req,
  input  logic [CH_W-1:0]         rd_ch,
  output logic                    rd_gnt,
  output logic [CH_W-1:0]         rd_gnt_ch,
  output logic [1:0]              fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // A scan lasts NUM_CHANNELS cycles. Allowing one more cycle keeps a tick from
  // ever landing inside a scan.
  localparam logic [DIV_WIDTH-1:0] MIN_PERIOD = DIV_WIDTH'(NUM_CHANNELS + 1);
  localparam logic [CH_W-1:0]      LAST_IDX   = CH_W'(NUM_CHANNELS - 1);
  localparam logic [FILL_W-1:0]    FULL_LEVEL = FILL_W'(SAMPLES_DEPTH);

  state_t                  state;
  logic [DIV_WIDTH-1:0]    divider;
  logic [CH_W-1:0]         idx;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic                    end_q;

  logic [DIV_WIDTH-1:0]    eff_period;
  logic [DIV_WIDTH-1:0]    tick_count;
  logic                    tick;
  logic                    drop;
  logic                    wr_en_next;
  logic                    gnt_next;
  logic [FILL_W-1:0]       fill_next;

  assign fsm_state = state;

  // Next-cycle decisions: period clamp, tick detect, write/grant and fill update.
  always_comb begin
    eff_period = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    tick_count = eff_period - DIV_WIDTH'(1);
    // If period is lowered while the divider is already past the new terminal
    // count, ">=" lets the divider recover on the next cycle. Without it the
    // divider would run all the way round.
    tick       = (divider >= tick_count);
    drop       = (state == ST_SCAN) && tick;
    wr_en_next = (state == ST_SCAN) && mask_q[idx];
    gnt_next   = rd_req && !rd_gnt && !wr_en_next;
    fill_next  = fill;
    if (clr) begin
      fill_next = '0;
    end else if (end_q && (fill != FULL_LEVEL)) begin
      fill_next = fill + FILL_W'(1);
    end
  end

  // Scheduler FSM, divider, scan index and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      divider    <= '0;
      idx        <= '0;
      mask_q     <= '0;
      end_q      <= 1'b0;
      wr_en      <= 1'b0;
      wr_ch      <= '0;
      frame_done <= 1'b0;
      fill       <= '0;
      buf_full   <= 1'b0;
      overrun    <= 1'b0;
      rd_gnt     <= 1'b0;
      rd_gnt_ch  <= '0;
    end else begin
      wr_en      <= wr_en_next;
      end_q      <= 1'b0;
      frame_done <= end_q;
      fill       <= fill_next;
      buf_full   <= (fill_next == FULL_LEVEL);
      rd_gnt     <= gnt_next;
      if (gnt_next) begin
        rd_gnt_ch <= rd_ch;
      end
      if (clr) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          divider <= '0;
          if (en) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!en) begin
            state   <= ST_IDLE;
            divider <= '0;
          end else if (tick) begin
            divider <= '0;
            mask_q  <= ch_mask;
            idx     <= '0;
            state   <= ST_SCAN;
          end else begin
            divider <= divider + DIV_WIDTH'(1);
          end
        end
        ST_SCAN: begin
          wr_ch <= idx;
          // The divider keeps running through the scan. A tick that lands here
          // is dropped and recorded as an overrun.
          if (tick) begin
            divider <= '0;
          end else begin
            divider <= divider + DIV_WIDTH'(1);
          end
          if (idx == LAST_IDX) begin
            end_q <= 1'b1;
            idx   <= '0;
            if (en) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_IDLE;
              divider <= '0;
            end
          end else begin
            idx <= idx + CH_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          divider <= '0;
        end
      endcase
    end
  end

`ifdef SCHED_OVERRUN_CNT_EN
  // Saturating count of dropped ticks. It is cleared together with the sticky flag.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      overrun_cnt <= '0;
    end else if (drop && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_capture_scheduler.sv
// Directed bench for sample_capture_scheduler. It combines a table of timed
// checkpoints for the first scan with hand-written sequences for the masking and
// saturation, period clamp, read contention, en drop and mid-scan reset cases.
// Write ordering is checked against an expected queue of channel indices.
module tb_sample_capture_scheduler;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [15:0] period = 16'd20;
  logic [13:0] ch_mask = 14'h3FFF;
  logic        clr = 1'b0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_ch = 4'd0;

  logic        wr_en;
  logic [3:0]  wr_ch;
  logic        frame_done;
  logic [3:0]  fill;
  logic        buf_full;
  logic        overrun;
  logic        rd_gnt;
  logic [3:0]  rd_gnt_ch;
  logic [1:0]  fsm_state;
`ifdef SCHED_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  logic prev_gnt = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  sample_capture_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .period     (period),
    .ch_mask    (ch_mask),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .frame_done (frame_done),
    .fill       (fill),
    .buf_full   (buf_full),
    .overrun    (overrun),
`ifdef SCHED_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .rd_req     (rd_req),
    .rd_ch      (rd_ch),
    .rd_gnt     (rd_gnt),
    .rd_gnt_ch  (rd_gnt_ch),
    .fsm_state  (fsm_state)
  );

  typedef struct {
    int         k;
    logic       wr_en;
    logic [3:0] wr_ch;
    logic       frame_done;
    logic [3:0] fill;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_scan(input logic [13:0] m);
    for (int i = 0; i < 14; i++) begin
      if (m[i]) exp_q.push_back(4'(i));
    end
  endtask

  task automatic wait_wr(input logic [3:0] ch, input int limit);
    int n;
    n = 0;
    while (!(wr_en && wr_ch == ch) && n < limit) begin
      cyc(1);
      n++;
    end
    check("wait_wr_reached", {31'b0, (wr_en && wr_ch == ch)}, 1);
  endtask

  task automatic wait_frame(input int limit, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!frame_done && n < limit);
    check("wait_frame_reached", {31'b0, frame_done}, 1);
  endtask

  // scoreboard: write order against exp_q, and grant rules
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr_en", {31'b0, wr_en}, 0);
        end else begin
          check("wr_ch_order", {28'b0, wr_ch}, {28'b0, exp_q.pop_front()});
        end
      end
      if (rd_gnt) begin
        check("gnt_with_wr_en", {31'b0, wr_en}, 0);
        check("gnt_back_to_back", {31'b0, prev_gnt}, 0);
      end
      prev_gnt = rd_gnt;
    end else begin
      prev_gnt = 1'b0;
    end
  end

  initial begin
    int n;

    // checkpoints for the first full-mask scan, k = edges after en is sampled
    vecs[0]  = '{0,  1'b0, 4'd0,  1'b0, 4'd0, S_WAIT};
    vecs[1]  = '{19, 1'b0, 4'd0,  1'b0, 4'd0, S_WAIT};
    vecs[2]  = '{20, 1'b0, 4'd0,  1'b0, 4'd0, S_SCAN};
    vecs[3]  = '{21, 1'b1, 4'd0,  1'b0, 4'd0, S_SCAN};
    vecs[4]  = '{22, 1'b1, 4'd1,  1'b0, 4'd0, S_SCAN};
    vecs[5]  = '{27, 1'b1, 4'd6,  1'b0, 4'd0, S_SCAN};
    vecs[6]  = '{33, 1'b1, 4'd12, 1'b0, 4'd0, S_SCAN};
    vecs[7]  = '{34, 1'b1, 4'd13, 1'b0, 4'd0, S_WAIT};
    vecs[8]  = '{35, 1'b0, 4'd0,  1'b1, 4'd1, S_WAIT};
    vecs[9]  = '{36, 1'b0, 4'd0,  1'b0, 4'd1, S_WAIT};
    vecs[10] = '{38, 1'b0, 4'd0,  1'b0, 4'd1, S_WAIT};

    // reset state
    cyc(3);
    check("rst_wr_en", {31'b0, wr_en}, 0);
    check("rst_wr_ch", {28'b0, wr_ch}, 0);
    check("rst_frame_done", {31'b0, frame_done}, 0);
    check("rst_fill", {28'b0, fill}, 0);
    check("rst_buf_full", {31'b0, buf_full}, 0);
    check("rst_overrun", {31'b0, overrun}, 0);
    check("rst_rd_gnt", {31'b0, rd_gnt}, 0);
    check("rst_rd_gnt_ch", {28'b0, rd_gnt_ch}, 0);
    check("rst_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
    reset = 1'b0;
    cyc(1);

    // basic scan, table driven
    period = 16'd20;
    ch_mask = 14'h3FFF;
    push_scan(14'h3FFF);
    en = 1'b1;
    begin
      int kk;
      kk = -1;
      for (int i = 0; i < NV; i++) begin
        cyc(vecs[i].k - kk);
        kk = vecs[i].k;
        check($sformatf("vec%0d_wr_en", i), {31'b0, wr_en}, {31'b0, vecs[i].wr_en});
        if (vecs[i].wr_en) check($sformatf("vec%0d_wr_ch", i), {28'b0, wr_ch}, {28'b0, vecs[i].wr_ch});
        check($sformatf("vec%0d_frame_done", i), {31'b0, frame_done}, {31'b0, vecs[i].frame_done});
        check($sformatf("vec%0d_fill", i), {28'b0, fill}, {28'b0, vecs[i].fill});
        check($sformatf("vec%0d_state", i), {30'b0, fsm_state}, {30'b0, vecs[i].st});
      end
    end
    en = 1'b0;
    cyc(1);
    check("wait_en_drop_idle", {30'b0, fsm_state}, {30'b0, S_IDLE});
    cyc(5);
    check("basic_queue_empty", exp_q.size(), 0);

    // masking and saturation
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_fill", {28'b0, fill}, 0);
    ch_mask = 14'h0005;
    for (int f = 0; f < 12; f++) push_scan(14'h0005);
    en = 1'b1;
    for (int f = 1; f <= 12; f++) begin
      wait_frame(60, n);
      if (f > 1) check("tick_spacing_20", n, 20);
      check($sformatf("sat_fill_f%0d", f), {28'b0, fill}, (f < 10) ? f : 10);
      check($sformatf("buf_full_f%0d", f), {31'b0, buf_full}, {31'b0, (f >= 10)});
    end
    en = 1'b0;
    cyc(25);
    check("mask_overrun", {31'b0, overrun}, 0);
    check("mask_state_idle", {30'b0, fsm_state}, {30'b0, S_IDLE});
    check("mask_queue_empty", exp_q.size(), 0);

    // period clamp, then clr coinciding with frame_done
    period = 16'd3;
    ch_mask = 14'h3FFF;
    for (int f = 0; f < 4; f++) push_scan(14'h3FFF);
    en = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      wait_frame(40, n);
      if (f > 1) check("clamp_spacing_15", n, 15);
      check("clamp_fill_held", {28'b0, fill}, 10);
    end
    en = 1'b0;
    wait_wr(4'd13, 20);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    check("clr_frame_done_pulse", {31'b0, frame_done}, 1);
    check("clr_wins_fill", {28'b0, fill}, 0);
    check("clr_buf_full", {31'b0, buf_full}, 0);
    check("clamp_overrun", {31'b0, overrun}, 0);
    cyc(2);
    check("clr_fill_stays", {28'b0, fill}, 0);
    check("clamp_state_idle", {30'b0, fsm_state}, {30'b0, S_IDLE});
    check("clamp_queue_empty", exp_q.size(), 0);

    // read in IDLE: granted after one cycle
    rd_req = 1'b1;
    rd_ch = 4'd3;
    cyc(1);
    check("idle_rd_gnt", {31'b0, rd_gnt}, 1);
    check("idle_rd_gnt_ch", {28'b0, rd_gnt_ch}, 3);
    rd_req = 1'b0;
    cyc(1);
    check("idle_rd_gnt_drop", {31'b0, rd_gnt}, 0);

    // read contention against a full-mask burst
    period = 16'd20;
    push_scan(14'h3FFF);
    en = 1'b1;
    wait_wr(4'd0, 30);
    rd_req = 1'b1;
    rd_ch = 4'd7;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!rd_gnt && n < 20);
    check("cont_rd_gnt", {31'b0, rd_gnt}, 1);
    check("cont_wait_cycles", n, 14);
    check("cont_rd_gnt_ch", {28'b0, rd_gnt_ch}, 7);
    check("cont_no_wr_at_gnt", {31'b0, wr_en}, 0);
    cyc(1);
    check("cont_gnt_gap", {31'b0, rd_gnt}, 0);
    cyc(1);
    check("cont_second_gnt", {31'b0, rd_gnt}, 1);
    rd_req = 1'b0;
    rd_ch = 4'd11;
    en = 1'b0;
    cyc(2);
    check("cont_gnt_off", {31'b0, rd_gnt}, 0);
    check("cont_gnt_ch_held", {28'b0, rd_gnt_ch}, 7);
    check("cont_fill", {28'b0, fill}, 1);
    check("cont_queue_empty", exp_q.size(), 0);

    // en dropped at wr_ch=5: scan completes, then IDLE
    push_scan(14'h3FFF);
    en = 1'b1;
    wait_wr(4'd5, 40);
    en = 1'b0;
    wait_frame(20, n);
    check("endrop_frame_latency", n, 9);
    check("endrop_fill", {28'b0, fill}, 2);
    check("endrop_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
    cyc(30);
    check("endrop_no_more_wr", {31'b0, wr_en}, 0);
    check("endrop_queue_empty", exp_q.size(), 0);

    // reset at wr_ch=9
    push_scan(14'h3FFF);
    en = 1'b1;
    wait_wr(4'd9, 40);
    reset = 1'b1;
    cyc(1);
    exp_q.delete();
    check("mrst_wr_en", {31'b0, wr_en}, 0);
    check("mrst_wr_ch", {28'b0, wr_ch}, 0);
    check("mrst_frame_done", {31'b0, frame_done}, 0);
    check("mrst_fill", {28'b0, fill}, 0);
    check("mrst_buf_full", {31'b0, buf_full}, 0);
    check("mrst_overrun", {31'b0, overrun}, 0);
    check("mrst_rd_gnt", {31'b0, rd_gnt}, 0);
    check("mrst_rd_gnt_ch", {28'b0, rd_gnt_ch}, 0);
    check("mrst_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
`ifdef SCHED_OVERRUN_CNT_EN
    check("mrst_overrun_cnt", {24'b0, overrun_cnt}, 0);
`endif
    en = 1'b0;
    reset = 1'b0;
    cyc(5);
    check("post_rst_state", {30'b0, fsm_state}, {30'b0, S_IDLE});
    check("post_rst_wr_en", {31'b0, wr_en}, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
